// File: rtl/alu_issue_ctrl.sv
// Issue/decode controller for the 32-bit datapath ALU: accept, execute, respond.
// Optional I-type immediate decode is enabled by defining ALU_IMM_EN.
module alu_issue_ctrl #(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 instr_valid_in,
    output logic                 instr_ready_out,
    input  logic [31:0]          instr_in,
    input  logic [BUS_WIDTH-1:0] rs_data_in,
    input  logic [BUS_WIDTH-1:0] rt_data_in,
    output logic [3:0]           alucontrol_out,
    output logic [BUS_WIDTH-1:0] s_out,
    output logic [BUS_WIDTH-1:0] t_out,
    output logic [4:0]           shamt_out,
    input  logic [BUS_WIDTH-1:0] alu_result_in,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic [BUS_WIDTH-1:0] result_out,
    output logic [4:0]           dest_out,
    output logic                 illegal_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic [BUS_WIDTH-1:0] s_q, s_d, t_q, t_d, result_q, result_d;
    logic [4:0]           shamt_q, shamt_d, dest_q, dest_d;
    logic                 illegal_q, illegal_d;

    logic [3:0]           dec_ctrl;
    logic [BUS_WIDTH-1:0] dec_s, dec_t;
    logic [4:0]           dec_shamt, dec_dest;
    logic                 dec_illegal;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = instr_in[31:26];
    assign funct  = instr_in[5:0];

`ifndef ALU_IMM_EN
    logic instr_unused;
    assign instr_unused = ^instr_in[25:16];
`endif

    // Illegal instructions decode to all-zero operands so nothing leaks to the ALU.
    always_comb begin
        dec_ctrl    = '0;
        dec_s       = '0;
        dec_t       = '0;
        dec_shamt   = '0;
        dec_dest    = '0;
        dec_illegal = 1'b1;
        if (opcode == 6'b000000) begin
            dec_illegal = 1'b0;
            unique case (funct)
                6'b000000:           dec_ctrl = 4'b1000;
                6'b000010:           dec_ctrl = 4'b1001;
                6'b000100:           dec_ctrl = 4'b0100;
                6'b000110:           dec_ctrl = 4'b0101;
                6'b100000, 6'b100001: dec_ctrl = 4'b0010;
                6'b100010, 6'b100011: dec_ctrl = 4'b0110;
                6'b100100:           dec_ctrl = 4'b0000;
                6'b100101:           dec_ctrl = 4'b0001;
                6'b100110:           dec_ctrl = 4'b0011;
                default:             dec_illegal = 1'b1;
            endcase
            if (!dec_illegal) begin
                dec_s     = rs_data_in;
                dec_t     = rt_data_in;
                dec_dest  = instr_in[15:11];
                dec_shamt = instr_in[10:6];
            end
        end
`ifdef ALU_IMM_EN
        else begin
            dec_illegal = 1'b0;
            unique case (opcode)
                6'b001000, 6'b001001: begin
                    dec_ctrl = 4'b0010;
                    dec_t    = {{(BUS_WIDTH-16){instr_in[15]}}, instr_in[15:0]};
                end
                6'b001100: begin
                    dec_ctrl = 4'b0000;
                    dec_t    = {{(BUS_WIDTH-16){1'b0}}, instr_in[15:0]};
                end
                6'b001101: begin
                    dec_ctrl = 4'b0001;
                    dec_t    = {{(BUS_WIDTH-16){1'b0}}, instr_in[15:0]};
                end
                6'b001110: begin
                    dec_ctrl = 4'b0011;
                    dec_t    = {{(BUS_WIDTH-16){1'b0}}, instr_in[15:0]};
                end
                default: dec_illegal = 1'b1;
            endcase
            if (!dec_illegal) begin
                dec_s    = rs_data_in;
                dec_dest = instr_in[20:16];
            end
        end
`endif
    end

    always_comb begin
        state_d          = state_q;
        ctrl_d           = ctrl_q;
        s_d              = s_q;
        t_d              = t_q;
        shamt_d          = shamt_q;
        dest_d           = dest_q;
        illegal_d        = illegal_q;
        result_d         = result_q;
        instr_ready_out  = 1'b0;
        result_valid_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                instr_ready_out = 1'b1;
                if (instr_valid_in) begin
                    state_d   = EXEC;
                    ctrl_d    = dec_ctrl;
                    s_d       = dec_s;
                    t_d       = dec_t;
                    shamt_d   = dec_shamt;
                    dest_d    = dec_dest;
                    illegal_d = dec_illegal;
                end
            end
            EXEC: begin
                state_d  = RESP;
                result_d = illegal_q ? '0 : alu_result_in;
            end
            RESP: begin
                result_valid_out = 1'b1;
                if (result_ready_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            s_q       <= '0;
            t_q       <= '0;
            shamt_q   <= '0;
            dest_q    <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            s_q       <= s_d;
            t_q       <= t_d;
            shamt_q   <= shamt_d;
            dest_q    <= dest_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
        end
    end

    assign alucontrol_out = ctrl_q;
    assign s_out          = s_q;
    assign t_out          = t_q;
    assign shamt_out      = shamt_q;
    assign dest_out       = dest_q;
    assign illegal_out    = illegal_q;
    assign result_out     = result_q;

endmodule
